// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// regfile_pkg : shared types and helpers for the bypassing register file
// Revision    : 1.0
// ============================================================================
package regfile_pkg;

  localparam logic [0:0] ST_INIT_ENC = 1'b0;
  localparam logic [0:0] ST_RUN_ENC  = 1'b1;

  typedef enum logic [0:0] {
    INIT = ST_INIT_ENC,
    RUN  = ST_RUN_ENC
  } state_t;

  localparam int ZERO_REG = 0;

  function automatic int regfile_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
// regfile_read_port : one read port - zero / bypass / array mux and busy lookup
// Revision          : 1.0
// ============================================================================
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              ready,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] regs [DEPTH],
  input  logic [DEPTH-1:0]  busy,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_busy
);

  logic addr_zero;
  logic wr_hit;

  assign addr_zero = (addr == ADDR_W'(ZERO_REG));
  assign wr_hit    = we && (wr_addr == addr);

  // A same-cycle write both supplies the data and resolves the hazard.
  always_comb begin
    rd_data = '0;
    rd_busy = 1'b0;
    if (ready && !addr_zero) begin
      rd_data = wr_hit ? wr_data : regs[addr];
      rd_busy = busy[addr] && !wr_hit;
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_bypass_sb.sv
`default_nettype none
// ============================================================================
// regfile_bypass_sb : N-read-port register file with write bypass, busy
//                     scoreboard and post-reset sequential clear
// Revision          : 1.0
// ============================================================================
module regfile_bypass_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NREAD*ADDR_W-1:0]  rd_addr,
  output logic [NREAD*DATA_W-1:0]  rd_data,
  output logic [NREAD-1:0]         rd_busy,
  input  logic                     rsv,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     flush,
  output logic                     ready
);

  localparam int DEPTH = regfile_depth(ADDR_W);

  state_t              state;
  logic [ADDR_W-1:0]   clr_idx;
  logic [DATA_W-1:0]   regs [DEPTH];
  logic [DEPTH-1:0]    busy;
  logic [DEPTH-1:0]    busy_nxt;
  logic                wr_valid;
  logic                rsv_valid;

  assign ready     = (state == RUN);
  assign wr_valid  = we  && (wr_addr  != ADDR_W'(ZERO_REG));
  assign rsv_valid = rsv && (rsv_addr != ADDR_W'(ZERO_REG));

  // clr_idx wraps to 0 on the last clear, leaving it ready for the next reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= INIT;
      clr_idx <= '0;
    end else if (state == INIT) begin
      clr_idx <= clr_idx + 1'b1;
      if (clr_idx == ADDR_W'(DEPTH - 1)) begin
        state <= RUN;
      end
    end
  end

  // Storage has no reset; INIT overwrites every entry before ready rises.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      regs[clr_idx] <= '0;
    end else if (wr_valid) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Later assignments win: a new reservation overrides a same-cycle write/flush.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end
    if (wr_valid) begin
      busy_nxt[wr_addr] = 1'b0;
    end
    if (rsv_valid) begin
      busy_nxt[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else if (state == RUN) begin
      busy <= busy_nxt;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_read_port
    regfile_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
    ) u_read_port (
      .ready   (ready),
      .addr    (rd_addr[i*ADDR_W +: ADDR_W]),
      .we      (we),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .regs    (regs),
      .busy    (busy),
      .rd_data (rd_data[i*DATA_W +: DATA_W]),
      .rd_busy (rd_busy[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_bypass_sb.sv
`default_nettype none
// ============================================================================
// tb_regfile_bypass_sb : directed scoreboard bench for regfile_bypass_sb
// Revision             : 1.0
// ============================================================================
module tb_regfile_bypass_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREAD  = 2;

  localparam int K_DATA0 = 0;
  localparam int K_DATA1 = 1;
  localparam int K_BUSY0 = 2;
  localparam int K_BUSY1 = 3;
  localparam int K_READY = 4;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] val;
  } exp_t;

  logic                    clk;
  logic                    rst_n;
  logic                    we;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic [NREAD*ADDR_W-1:0] rd_addr;
  logic [NREAD*DATA_W-1:0] rd_data;
  logic [NREAD-1:0]        rd_busy;
  logic                    rsv;
  logic [ADDR_W-1:0]       rsv_addr;
  logic                    flush;
  logic                    ready;

  exp_t q[$];
  int   tests;
  int   failed;

  regfile_bypass_sb #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREAD  (NREAD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .rsv      (rsv),
    .rsv_addr (rsv_addr),
    .flush    (flush),
    .ready    (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      K_DATA0: return rd_data[31:0];
      K_DATA1: return rd_data[63:32];
      K_BUSY0: return {31'd0, rd_busy[0]};
      K_BUSY1: return {31'd0, rd_busy[1]};
      default: return {31'd0, ready};
    endcase
  endfunction

  task automatic push(input string tag, input int kind, input logic [31:0] val);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.val  = val;
    q.push_back(e);
  endtask

  // Drain the scoreboard against DUT outputs at the falling edge.
  task automatic check();
    exp_t        e;
    logic [31:0] obs;
    @(negedge clk);
    while (q.size() > 0) begin
      e   = q.pop_front();
      obs = observe(e.kind);
      tests++;
      assert (obs === e.val)
      else begin
        failed++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int port, input logic [ADDR_W-1:0] a);
    rd_addr[port*ADDR_W +: ADDR_W] = a;
  endtask

  initial begin
    tests    = 0;
    failed   = 0;
    rst_n    = 1'b0;
    we       = 1'b1;
    wr_addr  = 5'd3;
    wr_data  = 32'hDEAD;
    rd_addr  = '0;
    rsv      = 1'b0;
    rsv_addr = '0;
    flush    = 1'b0;
    set_rd(0, 5'd3);

    // Reset state: outputs forced to zero.
    push("reset_ready", K_READY, 32'd0);
    push("reset_data0", K_DATA0, 32'd0);
    push("reset_busy0", K_BUSY0, 32'd0);
    check();
    tick();
    rst_n = 1'b1;

    // Clear sequence with a write to r3 held throughout.
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i == 31) begin
        push("init_ready_low_31", K_READY, 32'd0);
        push("init_data0_forced", K_DATA0, 32'd0);
        check();
      end
    end
    we = 1'b0;
    push("init_ready_high_32", K_READY, 32'd1);
    push("init_r3_ignored", K_DATA0, 32'd0);
    check();

    // Write with same-cycle bypass.
    tick();
    we = 1'b1; wr_addr = 5'd5; wr_data = 32'h12345678;
    set_rd(0, 5'd5);
    push("bypass_r5", K_DATA0, 32'h12345678);
    push("bypass_r5_busy", K_BUSY0, 32'd0);
    check();
    tick();
    we = 1'b0;
    push("stored_r5", K_DATA0, 32'h12345678);
    check();

    // Writes to r0 are discarded.
    tick();
    we = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    set_rd(1, 5'd0);
    push("r0_write_cycle", K_DATA1, 32'd0);
    check();
    tick();
    we = 1'b0;
    push("r0_after_write", K_DATA1, 32'd0);
    check();

    // Reserve r7, then resolve via write.
    tick();
    rsv = 1'b1; rsv_addr = 5'd7;
    set_rd(0, 5'd7);
    push("rsv7_same_cycle_busy", K_BUSY0, 32'd0);
    check();
    tick();
    rsv = 1'b0;
    push("rsv7_busy", K_BUSY0, 32'd1);
    push("rsv7_data", K_DATA0, 32'd0);
    check();
    we = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
    #1;
    push("wr7_busy_bypassed", K_BUSY0, 32'd0);
    push("wr7_data_bypass", K_DATA0, 32'h55);
    check();
    tick();
    we = 1'b0;
    push("wr7_busy_after", K_BUSY0, 32'd0);
    push("wr7_data_after", K_DATA0, 32'h55);
    check();

    // Reserve r11 so the flush has something to clear.
    rsv = 1'b1; rsv_addr = 5'd11;
    tick();
    rsv = 1'b0;
    set_rd(1, 5'd11);
    push("rsv11_busy", K_BUSY1, 32'd1);
    check();

    // Reserve beats same-cycle write and flush.
    rsv = 1'b1; rsv_addr = 5'd9;
    we = 1'b1; wr_addr = 5'd9; wr_data = 32'hCAFE0009;
    flush = 1'b1;
    tick();
    rsv = 1'b0; we = 1'b0; flush = 1'b0;
    set_rd(0, 5'd9);
    push("r9_busy_kept", K_BUSY0, 32'd1);
    push("r9_data_written", K_DATA0, 32'hCAFE0009);
    push("r11_flushed", K_BUSY1, 32'd0);
    check();
    for (int a = 1; a < 32; a++) begin
      if (a != 9) begin
        set_rd(1, 5'(a));
        push($sformatf("busy_clear_r%0d", a), K_BUSY1, 32'd0);
        check();
      end
    end

    // Mid-RUN reset pulse.
    tick();
    we = 1'b1; wr_addr = 5'd4; wr_data = 32'hA;
    tick();
    we = 1'b0;
    set_rd(0, 5'd4);
    set_rd(1, 5'd9);
    push("r4_written", K_DATA0, 32'hA);
    check();
    tick();
    rst_n = 1'b0;
    #1;
    push("midreset_ready", K_READY, 32'd0);
    push("midreset_data0", K_DATA0, 32'd0);
    check();
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i == 31) begin
        push("reinit_ready_low_31", K_READY, 32'd0);
        check();
      end
    end
    push("reinit_ready_high_32", K_READY, 32'd1);
    push("reinit_r4_cleared", K_DATA0, 32'd0);
    push("reinit_r9_not_busy", K_BUSY1, 32'd0);
    check();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
